// File: rtl/cmd_pkg.sv
// Shared definitions for the command assembler.
//   state_t       : assembler FSM states (IDLE, COLLECT)
//   DEF_NUM_BYTES : default bytes per command
//   DEF_TIMEOUT   : default inter-byte idle limit in clock cycles
//   timer_width() : counter width needed to hold TIMEOUT_CYCLES-1
package cmd_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int DEF_NUM_BYTES = 2;
  localparam int DEF_TIMEOUT   = 50000;

  // The idle counter never needs to hold more than TIMEOUT_CYCLES-1.
  // A limit of 0 (disabled), 1 or 2 still gets a 1-bit counter so the
  // vector is never zero-width.
  function automatic int timer_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer.
// Counts enabled cycles and raises a combinational expire pulse in the cycle
// where the count has reached TIMEOUT_CYCLES-1 while still enabled.
// TIMEOUT_CYCLES = 0 disables the timer entirely (expire never fires).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count back to 0 (has priority over enable)
//   enable   : count this cycle
//   expire   : limit reached this cycle (combinational, one cycle)
module idle_timer
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = timer_width(TIMEOUT_CYCLES);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  assign expire = ENABLED && enable && !clear && (count == LAST);

  // Saturates at LAST; expiry restarts the count so the next partial
  // command begins from zero.
  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_assembler.sv
// Assembles NUM_BYTES bytes from a UART receiver into one registered command.
//
// Handshakes:
//   rx_rdy/clr_rx_rdy   - a byte on rx_data is taken on every rising edge where
//                         rx_rdy=1; clr_rx_rdy mirrors rx_rdy combinationally
//                         so the receiver drops its flag after one cycle.
//   cmd_rdy/clr_cmd_rdy - cmd_rdy is set on the edge that completes a command
//                         and cleared by clr_cmd_rdy; a completion in the same
//                         cycle as clr_cmd_rdy wins, so no command is lost.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_rdy       : byte valid from receiver
//   rx_data      : received byte
//   clr_rx_rdy   : acknowledge to receiver (= rx_rdy)
//   clr_cmd_rdy  : consumer acknowledge of cmd
//   cmd          : last completed command (changes only on completion)
//   cmd_rdy      : a completed command is waiting
//   overrun      : sticky, a waiting command was overwritten
//   timeout      : one-cycle pulse, a partial command was dropped
//   byte_cnt     : bytes accepted into the current command
//   fsm_state    : debug view of the FSM (0 = IDLE, 1 = COLLECT)
module cmd_assembler
  import cmd_pkg::*;
#(
  parameter int NUM_BYTES      = DEF_NUM_BYTES,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_rdy,
  input  logic [7:0]                     rx_data,
  output logic                           clr_rx_rdy,
  input  logic                           clr_cmd_rdy,
  output logic [8*NUM_BYTES-1:0]         cmd,
  output logic                           cmd_rdy,
  output logic                           overrun,
  output logic                           timeout,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
  output logic                           fsm_state
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

  state_t        state;
  logic [W-1:0]  shreg;
  logic [W-1:0]  next_word;
  logic          complete;
  logic          ovr_event;
  logic          tmr_clear;
  logic          tmr_enable;
  logic          tmr_expire;

  assign clr_rx_rdy = rx_rdy;
  assign fsm_state  = (state == COLLECT);

  // Word as it looks once the byte on rx_data is shifted in. MSB-first
  // pushes older bytes upward; LSB-first enters at the top and walks down,
  // so after NUM_BYTES shifts the first byte sits in bits [7:0].
  always_comb begin
    next_word = '0;
    if (MSB_FIRST) begin
      next_word = (shreg << 8) | W'(rx_data);
    end else begin
      next_word = (shreg >> 8) | (W'(rx_data) << (W - 8));
    end
  end

  // byte_cnt is 0 in IDLE, so with NUM_BYTES=1 every byte completes at once.
  assign complete  = rx_rdy && (byte_cnt == LAST_IDX);
  assign ovr_event = complete && cmd_rdy && !clr_cmd_rdy;

  // Counter runs only while a partial command is waiting for more bytes;
  // any accepted byte restarts it, which also makes a byte arriving in the
  // would-be expiry cycle win over the timeout.
  assign tmr_clear  = rx_rdy || (state == IDLE);
  assign tmr_enable = (state == COLLECT) && !rx_rdy;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      shreg    <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmr_expire;

      if (complete) begin
        cmd <= next_word;
      end

      if (complete) begin
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      if (ovr_event) begin
        overrun <= 1'b1;
      end else if (clr_cmd_rdy) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_rdy) begin
            if (complete) begin
              shreg    <= '0;
              byte_cnt <= '0;
            end else begin
              shreg    <= next_word;
              byte_cnt <= byte_cnt + CW'(1);
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (rx_rdy) begin
            if (complete) begin
              shreg    <= '0;
              byte_cnt <= '0;
              state    <= IDLE;
            end else begin
              shreg    <= next_word;
              byte_cnt <= byte_cnt + CW'(1);
            end
          end else if (tmr_expire) begin
            shreg    <= '0;
            byte_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_assembler.sv
// Bench for cmd_assembler with two instances:
//   dut_a : NUM_BYTES=2, MSB_FIRST=1, TIMEOUT_CYCLES=10
//   dut_b : NUM_BYTES=4, MSB_FIRST=0, TIMEOUT_CYCLES=0 (timeout disabled)
// Expected commands are queued as bytes are issued; monitors pop and compare
// whenever a DUT presents a new command.
module tb_cmd_assembler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- dut_a signals ----------------
  logic        rx_rdy, clr_rx_rdy, clr_cmd_rdy, cmd_rdy, overrun, timeout, fsm_state;
  logic [7:0]  rx_data;
  logic [15:0] cmd;
  logic [1:0]  byte_cnt;

  // ---------------- dut_b signals ----------------
  logic        rx_rdy_b, clr_rx_rdy_b, clr_cmd_rdy_b, cmd_rdy_b, overrun_b, timeout_b, fsm_state_b;
  logic [7:0]  rx_data_b;
  logic [31:0] cmd_b;
  logic [2:0]  byte_cnt_b;

  cmd_assembler #(.NUM_BYTES(2), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .overrun(overrun),
    .timeout(timeout), .byte_cnt(byte_cnt), .fsm_state(fsm_state)
  );

  cmd_assembler #(.NUM_BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy_b), .rx_data(rx_data_b), .clr_rx_rdy(clr_rx_rdy_b),
    .clr_cmd_rdy(clr_cmd_rdy_b), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .overrun(overrun_b),
    .timeout(timeout_b), .byte_cnt(byte_cnt_b), .fsm_state(fsm_state_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp_b_q[$];
  logic [7:0]  part_a[$];
  logic [7:0]  part_b[$];
  int acks_sent = 0, acks_seen = 0, acks_b_sent = 0, acks_b_seen = 0;
  int tos_exp = 0, tos_seen = 0, tos_b_seen = 0;
  bit auto_ack = 0, ack_now = 0, auto_ack_b = 0, ack_now_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- drivers ----------------
  // One call = one clock cycle; returns 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    rx_rdy        = v;
    rx_data       = d;
    rx_rdy_b      = 1'b0;
    clr_cmd_rdy   = auto_ack ? cmd_rdy : ack_now;
    clr_cmd_rdy_b = auto_ack_b ? cmd_rdy_b : ack_now_b;
    if (v) acks_sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d);
    rx_rdy_b      = v;
    rx_data_b     = d;
    rx_rdy        = 1'b0;
    clr_cmd_rdy   = auto_ack ? cmd_rdy : ack_now;
    clr_cmd_rdy_b = auto_ack_b ? cmd_rdy_b : ack_now_b;
    if (v) acks_b_sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_a();
    ack_now = 1'b1;
    step(1'b0, 8'h00);
    ack_now = 1'b0;
  endtask

  task automatic ack_b();
    ack_now_b = 1'b1;
    step_b(1'b0, 8'h00);
    ack_now_b = 1'b0;
  endtask

  // ---------------- monitors ----------------
  logic        prev_rdy, prev_rdy_b;
  logic [15:0] prev_cmd, e_a;
  logic [31:0] prev_cmd_b, e_b;

  initial begin
    prev_rdy = 1'b0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (clr_rx_rdy) acks_seen++;
      if (rst) begin
        prev_rdy = 1'b0;
        prev_cmd = '0;
      end else begin
        if (timeout) tos_seen++;
        if (cmd_rdy && (!prev_rdy || cmd != prev_cmd)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL cmd_a_unexpected: got 0x%0h, expected no command", cmd);
          end else begin
            e_a = exp_q.pop_front();
            check("cmd_a", cmd, e_a);
          end
        end
        prev_rdy = cmd_rdy;
        prev_cmd = cmd;
      end
    end
  end

  initial begin
    prev_rdy_b = 1'b0; prev_cmd_b = '0;
    forever begin
      @(negedge clk);
      if (clr_rx_rdy_b) acks_b_seen++;
      if (rst) begin
        prev_rdy_b = 1'b0;
        prev_cmd_b = '0;
      end else begin
        if (timeout_b) tos_b_seen++;
        if (cmd_rdy_b && (!prev_rdy_b || cmd_b != prev_cmd_b)) begin
          if (exp_b_q.size() == 0) begin
            n_checks++;
            $display("FAIL cmd_b_unexpected: got 0x%0h, expected no command", cmd_b);
          end else begin
            e_b = exp_b_q.pop_front();
            check("cmd_b", cmd_b, e_b);
          end
        end
        prev_rdy_b = cmd_rdy_b;
        prev_cmd_b = cmd_b;
      end
    end
  end

  // ---------------- stimulus ----------------
  int          gap;
  int          tos_before;
  logic [7:0]  b;
  logic [7:0]  seq_b[8];

  initial begin
    rst = 1'b1;
    rx_rdy = 0; rx_data = 0; clr_cmd_rdy = 0;
    rx_rdy_b = 0; rx_data_b = 0; clr_cmd_rdy_b = 0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;

    // reset state
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_byte_cnt", byte_cnt, 2'd0);
    check("rst_cmd_b", cmd_b, 32'h0);
    check("rst_cmd_rdy_b", cmd_rdy_b, 1'b0);

    // two-byte MSB-first command
    exp_q.push_back(16'hA53C);
    step(1'b1, 8'hA5);
    check("a5_byte_cnt", byte_cnt, 2'd1);
    check("a5_cmd_rdy", cmd_rdy, 1'b0);
    check("a5_state", fsm_state, 1'b1);
    step(1'b1, 8'h3C);
    check("a53c_cmd", cmd, 16'hA53C);
    check("a53c_cmd_rdy", cmd_rdy, 1'b1);
    check("a53c_byte_cnt", byte_cnt, 2'd0);
    check("a53c_state", fsm_state, 1'b0);
    check("a53c_acks", acks_seen, 2);

    // overrun: second command while the first is still waiting
    exp_q.push_back(16'hBEEF);
    step(1'b1, 8'hBE);
    check("be_cmd_hold", cmd, 16'hA53C);
    step(1'b1, 8'hEF);
    check("beef_cmd", cmd, 16'hBEEF);
    check("beef_overrun", overrun, 1'b1);
    check("beef_cmd_rdy", cmd_rdy, 1'b1);
    ack_a();
    check("beef_ack_rdy", cmd_rdy, 1'b0);
    check("beef_ack_overrun", overrun, 1'b0);

    // ack coinciding with a completion: set wins, no overrun
    exp_q.push_back(16'h0102);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    exp_q.push_back(16'h0304);
    step(1'b1, 8'h03);
    ack_now = 1'b1;
    step(1'b1, 8'h04);
    ack_now = 1'b0;
    check("same_cyc_rdy", cmd_rdy, 1'b1);
    check("same_cyc_overrun", overrun, 1'b0);
    check("same_cyc_cmd", cmd, 16'h0304);
    ack_a();
    check("same_cyc_ack_rdy", cmd_rdy, 1'b0);

    // timeout after 10 idle cycles
    step(1'b1, 8'h55);
    repeat (9) step(1'b0, 8'h00);
    check("to_early_pulse", timeout, 1'b0);
    check("to_early_cnt", byte_cnt, 2'd1);
    step(1'b0, 8'h00);
    tos_exp++;
    check("to_pulse", timeout, 1'b1);
    check("to_byte_cnt", byte_cnt, 2'd0);
    check("to_state", fsm_state, 1'b0);
    check("to_cmd_kept", cmd, 16'h0304);
    check("to_rdy_kept", cmd_rdy, 1'b0);
    step(1'b0, 8'h00);
    check("to_pulse_end", timeout, 1'b0);
    exp_q.push_back(16'h1234);
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    check("to_next_cmd", cmd, 16'h1234);
    ack_a();

    // byte arriving in the would-be expiry cycle is accepted
    exp_q.push_back(16'h9ABC);
    step(1'b1, 8'h9A);
    repeat (9) step(1'b0, 8'h00);
    step(1'b1, 8'hBC);
    check("edge_no_timeout", timeout, 1'b0);
    check("edge_cmd", cmd, 16'h9ABC);
    check("edge_tos", tos_seen, tos_exp);
    ack_a();

    // reset mid-command
    step(1'b1, 8'h77);
    check("mid_byte_cnt", byte_cnt, 2'd1);
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    check("mid_rst_cnt", byte_cnt, 2'd0);
    check("mid_rst_cmd", cmd, 16'h0000);
    check("mid_rst_state", fsm_state, 1'b0);
    tos_before = tos_seen;
    repeat (12) step(1'b0, 8'h00);
    check("mid_rst_no_to", tos_seen, tos_before);
    exp_q.push_back(16'h0FF0);
    step(1'b1, 8'h0F);
    step(1'b1, 8'hF0);
    check("mid_rst_cmd2", cmd, 16'h0FF0);
    ack_a();

    // four-byte LSB-first instance
    exp_b_q.push_back(32'h44332211);
    step_b(1'b1, 8'h11);
    step_b(1'b1, 8'h22);
    step_b(1'b1, 8'h33);
    step_b(1'b1, 8'h44);
    check("b_cmd", cmd_b, 32'h44332211);
    check("b_cmd_rdy", cmd_rdy_b, 1'b1);
    exp_b_q.push_back(32'h88776655);
    for (int i = 0; i < 3; i++) begin
      step_b(1'b1, 8'h55 + 8'(i * 8'h11));
      check("b_cmd_hold", cmd_b, 32'h44332211);
    end
    check("b_byte_cnt", byte_cnt_b, 3'd3);
    step_b(1'b1, 8'h88);
    check("b_cmd2", cmd_b, 32'h88776655);
    check("b_overrun", overrun_b, 1'b1);
    ack_b();
    check("b_ack_overrun", overrun_b, 1'b0);

    // randomized traffic on dut_a, reference model works on byte lists
    auto_ack = 1'b1;
    for (int t = 0; t < 60; t++) begin
      gap = $urandom_range(0, 13);
      b   = 8'($urandom);
      if (part_a.size() > 0 && gap >= 10) begin
        part_a.delete();
        tos_exp++;
      end
      part_a.push_back(b);
      if (part_a.size() == 2) begin
        exp_q.push_back({part_a[0], part_a[1]});
        part_a.delete();
      end
      repeat (gap) step(1'b0, 8'h00);
      step(1'b1, b);
    end
    repeat (12) step(1'b0, 8'h00);
    if (part_a.size() > 0) begin
      part_a.delete();
      tos_exp++;
    end
    check("rand_a_tos", tos_seen, tos_exp);
    check("rand_a_overrun", overrun, 1'b0);
    check("rand_a_byte_cnt", byte_cnt, 2'd0);

    // randomized traffic on dut_b, long gaps must never time out
    auto_ack_b = 1'b1;
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 20);
      b   = 8'($urandom);
      part_b.push_back(b);
      if (part_b.size() == 4) begin
        for (int k = 0; k < 4; k++) seq_b[k] = part_b[k];
        exp_b_q.push_back({seq_b[3], seq_b[2], seq_b[1], seq_b[0]});
        part_b.delete();
      end
      repeat (gap) step_b(1'b0, 8'h00);
      step_b(1'b1, b);
    end
    repeat (4) step_b(1'b0, 8'h00);
    check("rand_b_byte_cnt", byte_cnt_b, 3'(part_b.size()));
    check("rand_b_no_timeout", tos_b_seen, 0);
    check("rand_b_overrun", overrun_b, 1'b0);

    // final accounting
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_b_q_drained", exp_b_q.size(), 0);
    check("acks_a", acks_seen, acks_sent);
    check("acks_b", acks_b_seen, acks_b_sent);
    check("timeouts_a", tos_seen, tos_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
